tft_sprite_motion_ctrl: RTL

- Per-frame motion controller for a bouncing image sprite on the 480x272 TFT.
- Detects the end of each active frame from pix_x/pix_y, then updates the sprite origin (x_move, y_move) once per frame. Updates use a programmable step and edge-bounce logic.
- Start/pause/stop are sequenced by a small FSM. Outputs feed the picture/ROM-read datapath as the window origin.
- Positions never change mid-frame.

---
 rtl/tft_pkg.sv | 33 +++
 rtl/tft_sprite_motion_ctrl_if.sv | 54 +++++
 rtl/tft_axis_bounce.sv | 79 +++++++
 rtl/tft_sprite_motion_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// -----------------------------------------------------------------------------
// tft_pkg
// Shared constants and types for the 480x272 TFT picture path.
//   H_VALID / V_VALID   : active pixels per line / active lines per frame
//   IMAGE_W / IMAGE_H   : sprite size
//   X_MAX / Y_MAX       : largest legal sprite origin on each axis
//   motion_state_e      : sprite motion FSM states
//   RGB565 colours      : palette used by the picture datapath
// -----------------------------------------------------------------------------
package tft_pkg;

    localparam int H_VALID = 480;
    localparam int V_VALID = 272;
    localparam int IMAGE_W = 100;
    localparam int IMAGE_H = 100;

    localparam int X_MAX = H_VALID - IMAGE_W;  // 380
    localparam int Y_MAX = V_VALID - IMAGE_H;  // 172

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } motion_state_e;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

endpackage

// File: rtl/tft_sprite_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// tft_sprite_motion_ctrl_if
// Signal bundle between the timing/control side (master) and the sprite
// motion controller (slave).
//   master drives : pix_x, pix_y, run_en, stop, step_x, step_y
//   slave drives  : x_move, y_move, x_dir, y_dir, frame_tick, bounce_x,
//                   bounce_y, busy, state (FSM debug view)
//   optional      : corner_hit, corner_cnt when TFT_MOTION_CORNER_CNT_EN
// There is no valid/ready handshake: pix_x/pix_y are a free-running raster
// position, control inputs are levels (run_en) or single-cycle pulses (stop),
// and every output is a registered level or one-cycle pulse.
// -----------------------------------------------------------------------------
interface tft_sprite_motion_ctrl_if;
    import tft_pkg::*;

    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic          run_en;
    logic          stop;
    logic [3:0]    step_x;
    logic [3:0]    step_y;
    logic [9:0]    x_move;
    logic [9:0]    y_move;
    logic          x_dir;
    logic          y_dir;
    logic          frame_tick;
    logic          bounce_x;
    logic          bounce_y;
    logic          busy;
    motion_state_e state;
`ifdef TFT_MOTION_CORNER_CNT_EN
    logic          corner_hit;
    logic [7:0]    corner_cnt;
`endif

    modport master (
`ifdef TFT_MOTION_CORNER_CNT_EN
        input  corner_hit, corner_cnt,
`endif
        output pix_x, pix_y, run_en, stop, step_x, step_y,
        input  x_move, y_move, x_dir, y_dir, frame_tick, bounce_x, bounce_y,
               busy, state
    );

    modport slave (
`ifdef TFT_MOTION_CORNER_CNT_EN
        output corner_hit, corner_cnt,
`endif
        input  pix_x, pix_y, run_en, stop, step_x, step_y,
        output x_move, y_move, x_dir, y_dir, frame_tick, bounce_x, bounce_y,
               busy, state
    );

endinterface

// File: rtl/tft_axis_bounce.sv
// -----------------------------------------------------------------------------
// tft_axis_bounce
// One-axis sprite origin update with edge bounce.
//   clk, rst : clock, synchronous active-high reset
//   tick     : apply one step this cycle
//   clear    : return to 0 / forward direction (wins over tick)
//   step     : pixels per step
//   pos      : origin, always within 0..LIMIT
//   dir      : 0 = increasing, 1 = decreasing
//   bounce   : one-cycle pulse, registered with the position that hit an edge
// -----------------------------------------------------------------------------
module tft_axis_bounce #(
    parameter int LIMIT = 380
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clear,
    input  logic [3:0] step,
    output logic [9:0] pos,
    output logic       dir,
    output logic       bounce
);

    localparam logic [10:0] LIMIT_W = 11'(LIMIT);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic        bounce_q, bounce_d;
    logic [10:0] sum;

    always_comb begin
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = 1'b0;
        // 11 bits so that pos + step can never wrap before the compare
        sum      = {1'b0, pos_q} + {7'd0, step};
        if (clear) begin
            pos_d = '0;
            dir_d = 1'b0;
        end else if (tick && (step != 4'd0)) begin
            // step == 0 holds everything, even when parked on an edge
            if (!dir_q) begin
                if (sum >= LIMIT_W) begin
                    pos_d    = 10'(LIMIT);
                    dir_d    = 1'b1;
                    bounce_d = 1'b1;
                end else begin
                    pos_d = sum[9:0];
                end
            end else begin
                if (pos_q <= {6'd0, step}) begin
                    pos_d    = '0;
                    dir_d    = 1'b0;
                    bounce_d = 1'b1;
                end else begin
                    pos_d = pos_q - {6'd0, step};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q    <= '0;
            dir_q    <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
        end
    end

    assign pos    = pos_q;
    assign dir    = dir_q;
    assign bounce = bounce_q;

endmodule

// File: rtl/tft_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tft_sprite_motion_ctrl
// Moves a 100x100 sprite around the 480x272 TFT once per frame with
// edge bounce. Positions only change on the edge after frame_tick, which
// follows the last active pixel, so the window never moves mid-frame.
//   tft_clk : pixel clock
//   sys_rst : synchronous active-high reset
//   bus     : tft_sprite_motion_ctrl_if.slave (raster position, run/stop
//             control, steps in; origin, directions, pulses, busy, state out)
// Optional macro TFT_MOTION_CORNER_CNT_EN adds corner_hit / corner_cnt.
// -----------------------------------------------------------------------------
module tft_sprite_motion_ctrl
    import tft_pkg::*;
(
    input  logic                     tft_clk,
    input  logic                     sys_rst,
    tft_sprite_motion_ctrl_if.slave  bus
);

    logic          eof;
    logic          eof_q;
    logic          tick_q;
    logic          move;
    motion_state_e state_q, state_d;

    assign eof = (bus.pix_x == 10'(H_VALID - 1)) && (bus.pix_y == 10'(V_VALID - 1));

    // Rising-edge detect: a stalled raster parked on the last pixel yields
    // only one tick.
    always_ff @(posedge tft_clk) begin
        if (sys_rst) begin
            eof_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            eof_q  <= eof;
            tick_q <= eof && !eof_q;
        end
    end

    always_ff @(posedge tft_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (tick_q) begin
            if (bus.run_en)            state_d = RUN;
            else if (state_q == RUN)   state_d = PAUSE;
        end
    end

    // Whichever state we are in, run_en at the tick means RUN with a step
    // applied on that same tick.
    assign move = tick_q && bus.run_en && !bus.stop;

    tft_axis_bounce #(.LIMIT(X_MAX)) u_axis_x (
        .clk    (tft_clk),
        .rst    (sys_rst),
        .tick   (move),
        .clear  (bus.stop),
        .step   (bus.step_x),
        .pos    (bus.x_move),
        .dir    (bus.x_dir),
        .bounce (bus.bounce_x)
    );

    tft_axis_bounce #(.LIMIT(Y_MAX)) u_axis_y (
        .clk    (tft_clk),
        .rst    (sys_rst),
        .tick   (move),
        .clear  (bus.stop),
        .step   (bus.step_y),
        .pos    (bus.y_move),
        .dir    (bus.y_dir),
        .bounce (bus.bounce_y)
    );

    assign bus.frame_tick = tick_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.state      = state_q;

`ifdef TFT_MOTION_CORNER_CNT_EN
    logic [7:0] corner_cnt_q;

    assign bus.corner_hit = bus.bounce_x && bus.bounce_y;

    always_ff @(posedge tft_clk) begin
        if (sys_rst || bus.stop) begin
            corner_cnt_q <= '0;
        end else if (bus.corner_hit && (corner_cnt_q != 8'hFF)) begin
            corner_cnt_q <= corner_cnt_q + 8'd1;
        end
    end

    assign bus.corner_cnt = corner_cnt_q;
`endif

endmodule
